// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle MIPS HI/LO multiply/divide unit
// Define MDU_DIV0_GUARD_EN to refuse divides by zero instead of running them.
module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

`ifdef MDU_DIV0_GUARD_EN
  localparam logic DIV0_GUARD = 1'b1;
`else
  localparam logic DIV0_GUARD = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [63:0] mul_u, mul_s;
  logic        is_signed;
  logic [31:0] mag_a, mag_b, uq, ur, quo, rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    mul_u = {32'b0, a_q} * {32'b0, b_q};
    mul_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    is_signed = ~op_q[0];
    mag_a = (is_signed && a_q[31]) ? -a_q : a_q;
    mag_b = (is_signed && b_q[31]) ? -b_q : b_q;
    if (b_q == 32'd0) begin
      uq = 32'hFFFF_FFFF;
      ur = mag_a;
    end else begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    quo = (is_signed && (a_q[31] ^ b_q[31])) ? -uq : uq;
    rem = (is_signed && a_q[31]) ? -ur : ur;
    if (b_q == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rem = a_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (!(DIV0_GUARD && md_op[1] && (b == 32'd0))) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            op_d    = md_op;
            cnt_d   = md_op[1] ? 4'd9 : 4'd4;
          end
        end else begin
          if (wr_hi) hi_d = a;
          if (wr_lo) lo_d = a;
        end
      end
      RUN: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          if (op_q[1]) begin
            hi_d = rem;
            lo_d = quo;
          end else if (op_q[0]) begin
            hi_d = mul_u[63:32];
            lo_d = mul_u[31:0];
          end else begin
            hi_d = mul_s[63:32];
            lo_d = mul_s[31:0];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 2'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed scoreboard bench for md_unit
// Expectations for divide-by-zero follow MDU_DIV0_GUARD_EN.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset, start, wr_hi, wr_lo;
  logic [1:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .a(a), .b(b), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drives one operation, optionally disturbing it with start/wr strobes mid-flight.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc, input bit poke);
    int n;
    logic [63:0] e;
    @(negedge clk);
    a = av; b = bv; md_op = op; start = 1'b1;
    exp_q.push_back({eh, el});
    m_hi = eh; m_lo = el;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (poke && n == 2) begin
        start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1; a = 32'hDEAD_BEEF; b = 32'd1; md_op = 2'b01;
      end else begin
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    check({tag, "_busy_cycles"}, 64'(n), 64'(ecyc));
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_hilo"}, {hi, lo}, e);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    md_op = 2'b00; a = 32'd0; b = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;

    // MTHI alone, then MTHI+MTLO together
    @(negedge clk); a = 32'h1234_5678; wr_hi = 1'b1;
    @(negedge clk); wr_hi = 1'b0; m_hi = 32'h1234_5678;
    check("mthi", {hi, lo}, {m_hi, m_lo});
    a = 32'hCAFE_F00D; wr_hi = 1'b1; wr_lo = 1'b1;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b0; m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;
    check("mthi_mtlo", {hi, lo}, {m_hi, m_lo});

    run_op("mult_neg2x3",  2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0);
    run_op("multu_max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, 1'b0);
    run_op("mult_minsq",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5, 1'b0);
    run_op("div_neg7by2",  2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
    run_op("div_7byneg2",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10, 1'b0);
    run_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10, 1'b0);
    // start/MTHI/MTLO strobes during busy must not disturb the operation
    run_op("divu_7by2_poked", 2'b11, 32'd7,      32'd2,         32'd1,         32'd3,         10, 1'b1);

`ifdef MDU_DIV0_GUARD_EN
    run_op("divu_5by0", 2'b11, 32'd5, 32'd0, m_hi, m_lo, 0, 1'b0);
    run_op("div_neg5by0", 2'b10, 32'hFFFF_FFFB, 32'd0, m_hi, m_lo, 0, 1'b0);
`else
    run_op("divu_5by0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10, 1'b0);
    run_op("div_neg5by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 10, 1'b0);
`endif

    // Reset on the 3rd busy cycle aborts the multiply
    @(negedge clk); a = 32'd100; b = 32'd200; md_op = 2'b00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("abort_busy1", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    check("abort_busy0", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    repeat (8) @(negedge clk);
    check("abort_nowrite", {hi, lo, 31'd0, busy}, 96'd0);

    run_op("multu_after_reset", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have port start, input, 1 bit: request a multiply/divide; driven high by decode for MULT/MULTU/DIV/DIVU.
REQ-004 The block SHALL have port md_op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 The block SHALL have port a, input, 32 bits: rs operand (multiplicand/dividend; MTHI/MTLO source).
REQ-006 The block SHALL have port b, input, 32 bits: rt operand (multiplier/divisor).
REQ-007 The block SHALL have port wr_hi, input, 1 bit: MTHI write strobe.
REQ-008 The block SHALL have port wr_lo, input, 1 bit: MTLO write strobe.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in flight; the pipeline stalls MFHI/MFLO/MTHI/MTLO/start while high.
REQ-010 The block SHALL have port hi, output, 32 bits: HI register.
REQ-011 The block SHALL have port lo, output, 32 bits: LO register.

Function
REQ-012 The block SHALL be an FSM with states IDLE and RUN, plus a 4-bit down-counter cnt.
REQ-013 In IDLE with start=1, the block SHALL latch a, b and md_op, enter RUN, and load cnt=4 for multiply or cnt=9 for divide.
REQ-014 busy SHALL equal (state==RUN), so it is high for exactly 5 cycles (multiply) or 10 cycles (divide), starting the cycle after start.
REQ-015 In RUN, cnt SHALL decrement each cycle; at the edge where cnt==0, hi/lo SHALL be written with the result and the state SHALL return to IDLE.
REQ-016 MULT SHALL produce the signed 64-bit product and MULTU the unsigned 64-bit product, with hi=[63:32] and lo=[31:0].
REQ-017 DIV/DIVU SHALL put the quotient in lo and the remainder in hi.
REQ-018 Signed division SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-019 Signed division 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-020 start while busy=1 SHALL be ignored; latched operands SHALL stay unchanged.
REQ-021 In IDLE, wr_hi SHALL load hi<=a and wr_lo SHALL load lo<=a; both may occur in the same cycle.
REQ-022 wr_hi/wr_lo while busy=1 SHALL be ignored.
REQ-023 When start and wr_hi/wr_lo are high in the same IDLE cycle, start SHALL win and the writes SHALL be dropped.
REQ-024 hi/lo SHALL hold their value at all times except on completion, MTHI/MTLO, or reset.

Reset
REQ-025 reset=0 at a rising edge SHALL force state=IDLE, cnt=0, busy=0, hi=0, lo=0, and clear the latched operands.
REQ-026 Reset mid-operation SHALL abort it; no result SHALL be written, and busy SHALL be 0 the cycle after.
REQ-027 Reset SHALL take priority over start, wr_hi and wr_lo.

Configuration
REQ-028 Macro MDU_DIV0_GUARD_EN SHALL control divide-by-zero behaviour.
REQ-029 With MDU_DIV0_GUARD_EN defined, DIV/DIVU with b==0 SHALL not enter RUN, busy SHALL stay 0, and hi/lo SHALL be unchanged.
REQ-030 Without MDU_DIV0_GUARD_EN, DIV/DIVU with b==0 SHALL run the full 10 cycles, then write lo=0xFFFFFFFF and hi=a for both signed and unsigned.

Verification
REQ-031 The bench SHALL cover MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 The bench SHALL cover MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
REQ-033 The bench SHALL cover DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; and DIVU 7/2 -> lo=3, hi=1.
REQ-034 The bench SHALL cover wr_hi=1, a=0x12345678 in IDLE -> hi=0x12345678 next cycle; the same strobe during busy -> hi unchanged.
REQ-035 The bench SHALL cover DIVU a=5, b=0 -> guard on: busy never rises, hi/lo unchanged; guard off: after 10 cycles lo=0xFFFFFFFF, hi=5.
REQ-036 The bench SHALL cover MULT started, then reset=0 on the 3rd busy cycle -> busy=0, hi=lo=0, no later write; a new start is then accepted normally.
